trig_interval_capture: RTL and testbench
========================================

# trig_interval_capture

Measures the number of CLK cycles between consecutive single-cycle trigger pulses, such as the TRIG_OUT stream of the team's generic counter, and presents each measured interval through a valid/acknowledge handshake. It is the receiving end of the counter's trigger interface. It serves as a capture/period-measurement peripheral for the processor's bus and timer logic, so software can verify or track tick rates.

## Interface
- COUNT_WIDTH, default 16: width of the interval counter and of INTERVAL_OUT.
- COUNT_MAX, default 65535: saturation value of the interval counter. Must be ≥ 2 and ≤ 2^COUNT_WIDTH − 1.

- CLK  input  1  system clock; all logic on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- ENABLE_IN  input  1  level; high = measuring allowed, low = return to IDLE.
- TRIG_IN  input  1  single-cycle pulse, synchronous to CLK. Each cycle high counts as one event.
- ACK_IN  input  1  consumer acknowledge for the current result.
- INTERVAL_OUT  output  COUNT_WIDTH  last captured interval, in CLK cycles.
- VALID_OUT  output  1  INTERVAL_OUT/OVF_OUT hold an unacknowledged result.
- OVF_OUT  output  1  captured interval saturated at COUNT_MAX; qualifies INTERVAL_OUT.
- LOST_OUT  output  1  sticky; at least one result was overwritten before acknowledge.
- BUSY_OUT  output  1  high while in MEASURE.

## Operation
- Reset state: IDLE. All outputs are 0, the counter is 0, and the overflow-in-progress flag is 0.
- State IDLE: counter held at 0, TRIG_IN ignored. ENABLE_IN=1 → ARM on the next edge.
- State ARM (waiting for the first edge): counter held at 0.
  - TRIG_IN=1 → MEASURE, counter ← 1, overflow-in-progress ← 0.
- State MEASURE, cycle with TRIG_IN=0:
  - If counter < COUNT_MAX: counter ← counter+1.
  - Else: counter stays at COUNT_MAX (saturates, never wraps) and overflow-in-progress ← 1.
- State MEASURE, cycle with TRIG_IN=1 (capture):
  - INTERVAL_OUT ← counter.
  - OVF_OUT ← overflow-in-progress.
  - VALID_OUT ← 1.
  - Counter ← 1 and overflow-in-progress ← 0; the next interval starts immediately, with no dead cycle.
- Interval definition: pulses at cycles t0 and t1 give INTERVAL_OUT = t1 − t0. Back-to-back pulses give 1.
- ENABLE_IN=0 in any state → IDLE on the next edge; counter and overflow-in-progress are cleared.
  - A pending result (VALID_OUT, INTERVAL_OUT, OVF_OUT, LOST_OUT) is retained until acknowledged.
  - TRIG_IN in the same cycle as ENABLE_IN=0 is ignored.
- Handshake:
  - ACK_IN=1 while VALID_OUT=1 clears VALID_OUT and LOST_OUT on the next edge.
  - INTERVAL_OUT and OVF_OUT keep their last value.
  - ACK_IN while VALID_OUT=0 has no effect.
- Capture while VALID_OUT=1 and ACK_IN=0: the new value overwrites, VALID_OUT stays 1, and LOST_OUT ← 1.
- Capture and ACK_IN=1 in the same cycle: the acknowledge applies to the old value. The new value is loaded, VALID_OUT stays 1, and LOST_OUT ← 0.
- BUSY_OUT = (state == MEASURE), registered.

## Timing
- All outputs are registered; no combinational path from input to output.
- Capture latency: TRIG_IN high at edge n → INTERVAL_OUT/OVF_OUT/VALID_OUT updated after edge n, visible in cycle n+1.
- ACK latency: ACK_IN sampled at edge n → VALID_OUT low in cycle n+1.
- BUSY_OUT rises in the cycle after the first TRIG_IN in ARM, and falls in the cycle after ENABLE_IN is sampled low.
- Reset is asserted asynchronously and deasserted synchronously upstream. Asserting it mid-interval discards the partial count and any pending result immediately.
- Maximum reportable interval is COUNT_MAX. Anything longer reports COUNT_MAX with OVF_OUT=1.

## Test plan
All scenarios use COUNT_WIDTH=8 and COUNT_MAX=200.
1. Enable, then TRIG_IN pulses at cycles 10, 30, 31 with ACK_IN tied high → two captures: INTERVAL_OUT=20 (OVF_OUT=0), then 1. VALID_OUT is high one cycle each. BUSY_OUT rises in cycle 11.
2. Pulses 250 cycles apart → INTERVAL_OUT=200 and OVF_OUT=1. The next pulse 50 cycles later gives INTERVAL_OUT=50 and OVF_OUT=0.
3. ACK_IN held low, pulses at intervals 5 then 7 → VALID_OUT=1, INTERVAL_OUT=7, LOST_OUT=1. A single ACK_IN clears VALID_OUT and LOST_OUT.
4. ACK_IN asserted in exactly the capture cycle of the second result → INTERVAL_OUT shows the new value, VALID_OUT stays 1, LOST_OUT=0.
5. Drop ENABLE_IN mid-interval with a pending result → IDLE, BUSY_OUT=0, and the pending result survives until ACK_IN. Re-enable and pulse at +0 then +12 → INTERVAL_OUT=12 (the first pulse after re-enable only arms).
6. Assert Reset between clock edges during MEASURE with VALID_OUT=1 → all outputs go to 0 immediately. After release, TRIG_IN is ignored until ENABLE_IN is seen and ARM is reached.

Source files
------------

// File: rtl/trig_interval_capture_if.sv
// Handshake bundle between the interval-capture block and its consumer.
// The slave side is the capture block; the master side drives enable, trigger and acknowledge.
interface trig_interval_capture_if #(
    parameter int COUNT_WIDTH = 16
);
    logic                   ENABLE_IN;
    logic                   TRIG_IN;
    logic                   ACK_IN;
    logic [COUNT_WIDTH-1:0] INTERVAL_OUT;
    logic                   VALID_OUT;
    logic                   OVF_OUT;
    logic                   LOST_OUT;
    logic                   BUSY_OUT;

    modport master (
        output ENABLE_IN,
        output TRIG_IN,
        output ACK_IN,
        input  INTERVAL_OUT,
        input  VALID_OUT,
        input  OVF_OUT,
        input  LOST_OUT,
        input  BUSY_OUT
    );

    modport slave (
        input  ENABLE_IN,
        input  TRIG_IN,
        input  ACK_IN,
        output INTERVAL_OUT,
        output VALID_OUT,
        output OVF_OUT,
        output LOST_OUT,
        output BUSY_OUT
    );
endinterface

// File: rtl/trig_interval_capture.sv
// Measures CLK cycles between consecutive trigger pulses and presents each interval
// through a valid/acknowledge handshake with overwrite (lost) and saturation (ovf) flags.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | disabled; counter held at 0, triggers ignored
// ST_ARM     | enabled, waiting for the first trigger to start timing
// ST_MEASURE | counting cycles; every trigger captures and restarts
module trig_interval_capture #(
    parameter int COUNT_WIDTH = 16,
    parameter int COUNT_MAX   = 65535
) (
    input  logic                        CLK,
    input  logic                        Reset,
    trig_interval_capture_if.slave      bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = COUNT_WIDTH'(COUNT_MAX);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    state_t                 state_q,    state_d;
    logic [COUNT_WIDTH-1:0] count_q,    count_d;
    logic                   ovf_ip_q,   ovf_ip_d;
    logic [COUNT_WIDTH-1:0] interval_q, interval_d;
    logic                   valid_q,    valid_d;
    logic                   ovf_q,      ovf_d;
    logic                   lost_q,     lost_d;
    logic                   busy_q,     busy_d;

    logic                   capture;
    logic                   ack_take;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            ovf_ip_q   <= 1'b0;
            interval_q <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            lost_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            ovf_ip_q   <= ovf_ip_d;
            interval_q <= interval_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
            lost_q     <= lost_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        ovf_ip_d   = ovf_ip_q;
        interval_d = interval_q;
        valid_d    = valid_q;
        ovf_d      = ovf_q;
        lost_d     = lost_q;
        capture    = 1'b0;
        ack_take   = valid_q && bus.ACK_IN;

        // Disable wins over everything in the measurement path, including a same-cycle trigger.
        if (!bus.ENABLE_IN) begin
            state_d  = ST_IDLE;
            count_d  = '0;
            ovf_ip_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARM;
                    count_d = '0;
                end
                ST_ARM: begin
                    count_d = '0;
                    if (bus.TRIG_IN) begin
                        state_d  = ST_MEASURE;
                        count_d  = CNT_ONE;
                        ovf_ip_d = 1'b0;
                    end
                end
                ST_MEASURE: begin
                    if (bus.TRIG_IN) begin
                        capture  = 1'b1;
                        count_d  = CNT_ONE;
                        ovf_ip_d = 1'b0;
                    end else if (count_q < CNT_MAX) begin
                        count_d = count_q + CNT_ONE;
                    end else begin
                        ovf_ip_d = 1'b1;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    count_d  = '0;
                    ovf_ip_d = 1'b0;
                end
            endcase
        end

        if (ack_take) begin
            valid_d = 1'b0;
            lost_d  = 1'b0;
        end

        // A same-cycle acknowledge consumes the old value, so only an unacked overwrite is lost.
        if (capture) begin
            interval_d = count_q;
            ovf_d      = ovf_ip_q;
            valid_d    = 1'b1;
            if (valid_q && !bus.ACK_IN) begin
                lost_d = 1'b1;
            end
        end

        busy_d = (state_d == ST_MEASURE);
    end

    assign bus.INTERVAL_OUT = interval_q;
    assign bus.VALID_OUT    = valid_q;
    assign bus.OVF_OUT      = ovf_q;
    assign bus.LOST_OUT     = lost_q;
    assign bus.BUSY_OUT     = busy_q;

endmodule

// File: tb/tb_trig_interval_capture.sv
// Directed bench for trig_interval_capture with a timestamp-based reference model
// compared every cycle, plus literal expectations at key points of each scenario.
module tb_trig_interval_capture;

    localparam int CW   = 8;
    localparam int CMAX = 200;

    logic CLK   = 1'b0;
    logic Reset = 1'b1;

    trig_interval_capture_if #(.COUNT_WIDTH(CW)) bus ();

    trig_interval_capture #(
        .COUNT_WIDTH(CW),
        .COUNT_MAX  (CMAX)
    ) dut (
        .CLK  (CLK),
        .Reset(Reset),
        .bus  (bus.slave)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: remembers the timestamp of the previous trigger while enabled.
    int cyc        = 0;
    bit m_active   = 1'b0;
    bit m_have_t0  = 1'b0;
    int m_t0       = 0;
    int e_interval = 0;
    int e_valid    = 0;
    int e_ovf      = 0;
    int e_lost     = 0;
    int e_busy     = 0;

    always @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            m_active   = 1'b0;
            m_have_t0  = 1'b0;
            e_interval = 0;
            e_valid    = 0;
            e_ovf      = 0;
            e_lost     = 0;
            e_busy     = 0;
        end else begin
            bit cap;
            int iv;
            bit acked;
            cap   = 1'b0;
            iv    = 0;
            acked = (e_valid == 1) && bus.ACK_IN;
            cyc++;
            if (!bus.ENABLE_IN) begin
                m_active  = 1'b0;
                m_have_t0 = 1'b0;
            end else if (!m_active) begin
                m_active = 1'b1;
            end else if (bus.TRIG_IN) begin
                if (m_have_t0) begin
                    cap = 1'b1;
                    iv  = cyc - m_t0;
                end
                m_t0      = cyc;
                m_have_t0 = 1'b1;
            end
            if (cap) begin
                if (e_valid == 1 && !bus.ACK_IN) e_lost = 1;
                else if (acked) e_lost = 0;
                e_interval = (iv > CMAX) ? CMAX : iv;
                e_ovf      = (iv > CMAX) ? 1 : 0;
                e_valid    = 1;
            end else if (acked) begin
                e_valid = 0;
                e_lost  = 0;
            end
            e_busy = m_have_t0 ? 1 : 0;
        end
    end

    always @(negedge CLK) begin
        check("cmp_interval", 32'(bus.INTERVAL_OUT), e_interval);
        check("cmp_valid",    32'(bus.VALID_OUT),    e_valid);
        check("cmp_ovf",      32'(bus.OVF_OUT),      e_ovf);
        check("cmp_lost",     32'(bus.LOST_OUT),     e_lost);
        check("cmp_busy",     32'(bus.BUSY_OUT),     e_busy);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Trigger high for exactly one rising edge; returns on the negedge after that edge.
    task automatic pulse();
        bus.TRIG_IN = 1'b1;
        @(negedge CLK);
        bus.TRIG_IN = 1'b0;
    endtask

    task automatic ack_once();
        bus.ACK_IN = 1'b1;
        @(negedge CLK);
        bus.ACK_IN = 1'b0;
    endtask

    initial begin
        bus.ENABLE_IN = 1'b0;
        bus.TRIG_IN   = 1'b0;
        bus.ACK_IN    = 1'b0;
        Reset         = 1'b1;
        idle(2);
        check("rst_valid",    32'(bus.VALID_OUT), 0);
        check("rst_interval", 32'(bus.INTERVAL_OUT), 0);
        check("rst_busy",     32'(bus.BUSY_OUT), 0);
        Reset = 1'b0;

        // Scenario 1: ack tied high, intervals 20 then 1
        bus.ACK_IN    = 1'b1;
        bus.ENABLE_IN = 1'b1;
        idle(3);
        check("s1_busy_pre", 32'(bus.BUSY_OUT), 0);
        pulse();
        check("s1_busy_rise", 32'(bus.BUSY_OUT), 1);
        check("s1_valid_arm", 32'(bus.VALID_OUT), 0);
        idle(19);
        pulse();
        check("s1_int20", 32'(bus.INTERVAL_OUT), 20);
        check("s1_ovf20", 32'(bus.OVF_OUT), 0);
        check("s1_valid20", 32'(bus.VALID_OUT), 1);
        pulse();
        check("s1_int1", 32'(bus.INTERVAL_OUT), 1);
        check("s1_valid1", 32'(bus.VALID_OUT), 1);
        idle(1);
        check("s1_valid_clr", 32'(bus.VALID_OUT), 0);

        // Scenario 2: saturation and the exact COUNT_MAX boundary
        idle(249);
        pulse();
        check("s2_int250", 32'(bus.INTERVAL_OUT), 200);
        check("s2_ovf250", 32'(bus.OVF_OUT), 1);
        idle(49);
        pulse();
        check("s2_int50", 32'(bus.INTERVAL_OUT), 50);
        check("s2_ovf50", 32'(bus.OVF_OUT), 0);
        idle(199);
        pulse();
        check("s2_int200", 32'(bus.INTERVAL_OUT), 200);
        check("s2_ovf200", 32'(bus.OVF_OUT), 0);
        idle(200);
        pulse();
        check("s2_int201", 32'(bus.INTERVAL_OUT), 200);
        check("s2_ovf201", 32'(bus.OVF_OUT), 1);

        // Scenario 3: ack held low, overwrite sets lost
        idle(1);
        bus.ACK_IN = 1'b0;
        idle(3);
        pulse();
        check("s3_int5", 32'(bus.INTERVAL_OUT), 5);
        check("s3_lost5", 32'(bus.LOST_OUT), 0);
        idle(6);
        pulse();
        check("s3_int7", 32'(bus.INTERVAL_OUT), 7);
        check("s3_valid7", 32'(bus.VALID_OUT), 1);
        check("s3_lost7", 32'(bus.LOST_OUT), 1);
        ack_once();
        check("s3_valid_ack", 32'(bus.VALID_OUT), 0);
        check("s3_lost_ack", 32'(bus.LOST_OUT), 0);
        check("s3_int_hold", 32'(bus.INTERVAL_OUT), 7);

        // Scenario 4: ack in the same cycle as the next capture
        idle(1);
        pulse();
        check("s4_int3", 32'(bus.INTERVAL_OUT), 3);
        idle(3);
        bus.ACK_IN = 1'b1;
        pulse();
        bus.ACK_IN = 1'b0;
        check("s4_int4", 32'(bus.INTERVAL_OUT), 4);
        check("s4_valid4", 32'(bus.VALID_OUT), 1);
        check("s4_lost4", 32'(bus.LOST_OUT), 0);
        ack_once();
        check("s4_valid_ack", 32'(bus.VALID_OUT), 0);

        // Scenario 5: disable with a pending result, then re-enable
        idle(8);
        pulse();
        check("s5_int10", 32'(bus.INTERVAL_OUT), 10);
        idle(3);
        bus.ENABLE_IN = 1'b0;
        pulse();
        check("s5_busy_off", 32'(bus.BUSY_OUT), 0);
        check("s5_valid_kept", 32'(bus.VALID_OUT), 1);
        check("s5_int_kept", 32'(bus.INTERVAL_OUT), 10);
        idle(5);
        pulse();
        check("s5_valid_idle", 32'(bus.VALID_OUT), 1);
        ack_once();
        check("s5_valid_ack", 32'(bus.VALID_OUT), 0);
        bus.ENABLE_IN = 1'b1;
        idle(1);
        pulse();
        check("s5_busy_rearm", 32'(bus.BUSY_OUT), 1);
        check("s5_valid_rearm", 32'(bus.VALID_OUT), 0);
        idle(11);
        pulse();
        check("s5_int12", 32'(bus.INTERVAL_OUT), 12);
        check("s5_valid12", 32'(bus.VALID_OUT), 1);

        // Scenario 6: async reset mid-measure with a pending result
        idle(4);
        check("s6_busy_pre", 32'(bus.BUSY_OUT), 1);
        #3 Reset = 1'b1;
        #1;
        check("s6_rst_valid", 32'(bus.VALID_OUT), 0);
        check("s6_rst_int", 32'(bus.INTERVAL_OUT), 0);
        check("s6_rst_busy", 32'(bus.BUSY_OUT), 0);
        check("s6_rst_lost", 32'(bus.LOST_OUT), 0);
        check("s6_rst_ovf", 32'(bus.OVF_OUT), 0);
        @(negedge CLK);
        Reset = 1'b0;
        pulse();
        check("s6_ign_busy", 32'(bus.BUSY_OUT), 0);
        pulse();
        check("s6_arm_busy", 32'(bus.BUSY_OUT), 1);
        check("s6_arm_valid", 32'(bus.VALID_OUT), 0);
        idle(7);
        pulse();
        check("s6_int8", 32'(bus.INTERVAL_OUT), 8);
        check("s6_valid8", 32'(bus.VALID_OUT), 1);

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
